mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the rv32i pipeline, sitting directly downstream of the execute stage and upstream of write-back. It takes the ALU result and register operand from execute and runs a request/acknowledge handshake with data memory for loads and stores. It produces byte enables, aligns and sign-extends load data, and presents one registered write-back result per accepted instruction. Non-memory instructions pass through with one cycle of latency.

## Interface
- ACK_TIMEOUT, 255: cycles in ACCESS without `dmem_ack` before the access is aborted as a bus error; range 1..65535.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  stage can accept; equals (state == IDLE).
- is_load  in  1  instruction is a load.
- is_store  in  1  instruction is a store.
- funct3  in  3  size/sign encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- alu_result  in  32  effective address for loads/stores, passthrough value otherwise.
- store_data  in  32  rs2 value for stores.
- rd  in  5  destination register.
- reg_we  in  1  instruction writes rd.
- wb_valid  out  1  one-cycle pulse per completed instruction.
- wb_rd  out  5  registered rd.
- wb_we  out  1  registered write enable; forced 0 for stores and errors.
- wb_data  out  32  passthrough or aligned load data.
- err  out  1  one-cycle pulse, coincident with wb_valid, on timeout or misalignment.
- dmem_req  out  1  access request; held until ack or timeout.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word-aligned address ({alu_result[31:2], 2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  memory completes the access in the cycle where req & ack.
- dmem_rdata  in  32  load word, valid when ack is high.

## Operation
- States: IDLE, ACCESS.
- Accept: `in_valid & in_ready` at a rising edge.
- Non-memory accept: stays in IDLE.
- Memory accept: latches address, size, store data and rd, then moves to ACCESS. `is_load` takes priority if `is_load` and `is_store` are both set.
- ACCESS with `dmem_ack`: returns to IDLE, pulses `wb_valid`.
- ACCESS with timeout counter reaching ACK_TIMEOUT: returns to IDLE, pulses `wb_valid` and `err`, `wb_we` = 0. An ack on the timeout cycle wins: normal completion, no err.
- Stores:
  - SB: `be` = 0001 << addr[1:0], `wdata` = byte replicated ×4.
  - SH: `be` = 0011 << {addr[1],1'b0}, `wdata` = half replicated ×2.
  - SW: `be` = 1111.
- Loads: select the byte/half by address low bits. B and H sign-extend; BU and HU zero-extend.
- Undefined funct3 (011, 110, 111) is treated as word.
- `in_valid` while `in_ready` = 0 is ignored. Upstream holds its instruction (stall).

## Timing
- Reset values: all outputs 0, state IDLE, timeout counter 0. `in_ready` is 1 after reset.
- Reset mid-access drops `dmem_req` asynchronously, with no completion pulse.
- Non-memory latency: `wb_valid` in the cycle after the accept edge. Back-to-back throughput: 1 per cycle.
- Memory latency: `dmem_req` rises the cycle after accept. `wb_valid` rises the cycle after the ack edge. Minimum 2 cycles accept-to-wb_valid when ack is immediate.
- `dmem_addr`, `be`, `we` and `wdata` are registered and stable for the whole of ACCESS.
- The timeout counter clears on entering ACCESS and increments each ACCESS cycle without ack.

## Configuration
- MEM_STAGE_MISALIGN_TRAP_EN defined:
  - Misalignment means H with addr[0] = 1, or W with addr[1:0] ≠ 0.
  - A misaligned access issues no dmem request and stays in IDLE.
  - `wb_valid` and `err` pulse one cycle after accept, with `wb_we` = 0.
- Undefined: address bits below the access size are ignored (H uses addr[1], W forces lane 0). err is raised only on timeout.

## Structure
- Shared package `rv32i_pkg` holds:
  - funct3 load/store encodings (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the `mem_state_t` enum (IDLE, ACCESS).
- Sub-module `load_align` is a combinational lane select plus sign/zero extension: rdata, addr[1:0], funct3 → 32-bit result. It is reused by any future cache path.

## Test plan
- Passthrough: three consecutive non-memory ops with alu_result 5, 6, 7 → wb_data 5, 6, 7 on consecutive cycles, `in_ready` constant 1.
- LB at addr 0x103, rdata 0x80FF_FF11, immediate ack → `dmem_addr` 0x100, wb_data 0xFFFF_FF80, wb_valid 2 cycles after accept.
- SH at addr 0x202, store_data 0x1234_ABCD → `be` 1100, `wdata` 0xABCD_ABCD, `wb_we` 0.
- Ack delayed 4 cycles → `in_ready` low, `dmem_req` held with stable address, then one wb_valid. ACK_TIMEOUT = 3 with no ack → err pulse, `wb_we` 0.
- LW at 0x101 → with macro: err, no dmem_req. Without macro: `dmem_addr` 0x100, no err.
- `rst_n` low during ACCESS → `dmem_req` 0 immediately, no wb_valid, `in_ready` 1 after release.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions: load/store funct3 encodings, access sizes and
// the memory-stage state type.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_t;

  // Access size from funct3; encodings with no defined meaning act as word.
  function automatic mem_size_t size_of(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the byte/half lane addressed by addr_lo out of
// the memory word and sign- or zero-extends it to 32 bits.
module load_align
  import rv32i_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane select and extension; halfwords only look at addr_lo[1].
  always_comb begin
    lane_b = '0;
    lane_h = '0;
    result = rdata;
    case (addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size_of(funct3))
      SZ_B:    result = {{24{lane_b[7] & (funct3 == F3_B)}}, lane_b};
      SZ_H:    result = {{16{lane_h[15] & (funct3 == F3_H)}}, lane_h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rv32i memory-access stage: req/ack handshake with data memory, byte
// enables, store lane replication, load alignment and a registered
// write-back result. Non-memory instructions pass through in one cycle.
// Optional macro MEM_STAGE_MISALIGN_TRAP_EN: misaligned H/W accesses are
// reported as errors without touching memory.
//
// state  | meaning
// IDLE   | ready for a new instruction; non-memory ops complete from here
// ACCESS | dmem_req held, waiting for dmem_ack or the ack timeout
module mem_stage
  import rv32i_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  input  logic        reg_we,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_we,
  output logic [31:0] wb_data,
  output logic        err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  // Last counter value before the access is abandoned.
  localparam logic [15:0] CNT_LAST = 16'(ACK_TIMEOUT - 1);

  mem_state_t  state;
  logic [15:0] cnt;
  logic [1:0]  addr_lo_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        we_q;

  logic        is_mem;
  logic        misaligned;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [31:0] load_word;

  assign in_ready = (state == IDLE);
  assign is_mem   = is_load | is_store;

  load_align u_load_align (
    .rdata   (dmem_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (f3_q),
    .result  (load_word)
  );

  // Byte enables, replicated store data and misalignment for the incoming op.
  always_comb begin
    be_in      = 4'b1111;
    wdata_in   = store_data;
    misaligned = 1'b0;
    case (size_of(funct3))
      SZ_B: begin
        be_in    = 4'b0001 << alu_result[1:0];
        wdata_in = {4{store_data[7:0]}};
      end
      SZ_H: begin
        be_in    = 4'b0011 << {alu_result[1], 1'b0};
        wdata_in = {2{store_data[15:0]}};
      end
      default: begin
        be_in    = 4'b1111;
        wdata_in = store_data;
      end
    endcase
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    case (size_of(funct3))
      SZ_H:    misaligned = alu_result[0];
      SZ_W:    misaligned = (alu_result[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
`endif
  end

  // Stage FSM with registered memory and write-back outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_lo_q  <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
      we_q       <= 1'b0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_we      <= 1'b0;
      wb_data    <= '0;
      err        <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
    end else begin
      wb_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!is_mem) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd;
              wb_we    <= reg_we;
              wb_data  <= alu_result;
            end else if (misaligned) begin
              wb_valid <= 1'b1;
              err      <= 1'b1;
              wb_rd    <= rd;
              wb_we    <= 1'b0;
              wb_data  <= '0;
            end else begin
              state      <= ACCESS;
              cnt        <= '0;
              dmem_req   <= 1'b1;
              dmem_we    <= ~is_load;
              dmem_addr  <= {alu_result[31:2], 2'b00};
              dmem_be    <= be_in;
              dmem_wdata <= is_load ? 32'd0 : wdata_in;
              addr_lo_q  <= alu_result[1:0];
              f3_q       <= funct3;
              rd_q       <= rd;
              we_q       <= reg_we & is_load;
            end
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            // An ack on the final timeout cycle still completes normally.
            state    <= IDLE;
            dmem_req <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_we    <= we_q;
            wb_data  <= dmem_we ? 32'd0 : load_word;
          end else if (cnt == CNT_LAST) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
            wb_valid <= 1'b1;
            err      <= 1'b1;
            wb_rd    <= rd_q;
            wb_we    <= 1'b0;
            wb_data  <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized
// instruction mix against a byte-level reference model.
module tb_mem_stage;

  localparam int TO = 6;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        reg_we;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [31:0] wb_data;
  logic        err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  mem_stage #(.ACK_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .alu_result (alu_result),
    .store_data (store_data),
    .rd         (rd),
    .reg_we     (reg_we),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_we      (wb_we),
    .wb_data    (wb_data),
    .err        (err),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  // first byte lane touched (low address bits below the size are ignored)
  function automatic int lane_off(input logic [31:0] addr, input logic [2:0] f3);
    int n;
    n = nbytes(f3);
    return (n == 4) ? 0 : (int'(addr[1:0]) / n) * n;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [31:0] addr,
                                         input logic [2:0] f3);
    int n;
    int off;
    logic [31:0] mask;
    logic [31:0] v;
    n    = nbytes(f3);
    off  = lane_off(addr, f3);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    v    = (rdata >> (8 * off)) & mask;
    if ((f3 == 3'd0 || f3 == 3'd1) && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] addr, input logic [2:0] f3);
    logic [3:0] be;
    int off;
    int n;
    be  = '0;
    off = lane_off(addr, f3);
    n   = nbytes(f3);
    for (int i = 0; i < 4; i++) if (i >= off && i < off + n) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] sd, input logic [2:0] f3);
    case (nbytes(f3))
      1:       return {24'd0, sd[7:0]} * 32'h0101_0101;
      2:       return {16'd0, sd[15:0]} * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  function automatic bit m_misal(input logic [31:0] addr, input logic [2:0] f3);
    return TRAP && (nbytes(f3) > 1) && ((int'(addr[1:0]) % nbytes(f3)) != 0);
  endfunction

  // ---------------- stimulus ----------------
  task automatic junk_inputs();
    is_load    = 1'($urandom);
    is_store   = 1'($urandom);
    funct3     = 3'($urandom);
    alu_result = $urandom;
    store_data = $urandom;
    rd         = 5'($urandom);
    reg_we     = 1'($urandom);
  endtask

  // One instruction, started and ended at a negedge with the stage idle.
  // d = number of request cycles the memory lets pass before acking.
  task automatic do_op(input string tag, input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] r,
                       input bit we, input int d, input logic [31:0] rdata);
    bit mem;
    bit mis;
    bit exp_err;
    bit acked;
    mem = ld | st;
    mis = mem && m_misal(addr, f3);
    chk({tag, ":ready_in"}, 32'(in_ready), 32'd1);
    in_valid   = 1'b1;
    is_load    = ld;
    is_store   = st;
    funct3     = f3;
    alu_result = addr;
    store_data = sd;
    rd         = r;
    reg_we     = we;
    @(negedge clk);
    in_valid = 1'b0;
    junk_inputs();
    if (!mem || mis) begin
      chk({tag, ":wb_valid"}, 32'(wb_valid), 32'd1);
      chk({tag, ":err"}, 32'(err), 32'(mis));
      chk({tag, ":wb_rd"}, 32'(wb_rd), 32'(r));
      chk({tag, ":wb_we"}, 32'(wb_we), mem ? 32'd0 : 32'(we));
      if (!mem) chk({tag, ":wb_data"}, wb_data, addr);
      chk({tag, ":no_req"}, 32'(dmem_req), 32'd0);
    end else begin
      chk({tag, ":req"}, 32'(dmem_req), 32'd1);
      chk({tag, ":dmem_we"}, 32'(dmem_we), 32'(!ld));
      chk({tag, ":addr"}, dmem_addr, {addr[31:2], 2'b00});
      if (!ld) begin
        chk({tag, ":be"}, 32'(dmem_be), 32'(m_be(addr, f3)));
        chk({tag, ":wdata"}, dmem_wdata, m_wdata(sd, f3));
      end
      acked = 1'b0;
      for (int k = 0; k < TO && !acked; k++) begin
        chk({tag, ":req_held"}, 32'(dmem_req), 32'd1);
        chk({tag, ":addr_stable"}, dmem_addr, {addr[31:2], 2'b00});
        chk({tag, ":busy"}, 32'(in_ready), 32'd0);
        chk({tag, ":no_wb_yet"}, 32'(wb_valid), 32'd0);
        acked      = (k == d);
        dmem_ack   = acked;
        dmem_rdata = acked ? rdata : $urandom;
        in_valid   = 1'(($urandom % 2));
        @(negedge clk);
        dmem_ack = 1'b0;
        in_valid = 1'b0;
      end
      exp_err = (d >= TO);
      chk({tag, ":wb_valid"}, 32'(wb_valid), 32'd1);
      chk({tag, ":err"}, 32'(err), 32'(exp_err));
      chk({tag, ":wb_rd"}, 32'(wb_rd), 32'(r));
      chk({tag, ":wb_we"}, 32'(wb_we), 32'(ld && we && !exp_err));
      if (ld && !exp_err) chk({tag, ":wb_data"}, wb_data, m_load(rdata, addr, f3));
      chk({tag, ":req_drop"}, 32'(dmem_req), 32'd0);
      chk({tag, ":ready_out"}, 32'(in_ready), 32'd1);
    end
    @(negedge clk);
    chk({tag, ":pulse"}, 32'(wb_valid), 32'd0);
    chk({tag, ":err_pulse"}, 32'(err), 32'd0);
  endtask

  logic [31:0] pt_val [$];

  initial begin
    logic [2:0] st_f3 [6];
    st_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    junk_inputs();
    repeat (2) @(negedge clk);
    chk("rst:ready", 32'(in_ready), 32'd1);
    chk("rst:wb_valid", 32'(wb_valid), 32'd0);
    chk("rst:err", 32'(err), 32'd0);
    chk("rst:req", 32'(dmem_req), 32'd0);
    chk("rst:wb_data", wb_data, 32'd0);
    chk("rst:addr", dmem_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst:wb_valid", 32'(wb_valid), 32'd0);

    // back-to-back passthrough 5, 6, 7, then random values
    pt_val = '{32'd5, 32'd6, 32'd7};
    repeat (12) pt_val.push_back($urandom);
    for (int i = 0; i <= pt_val.size(); i++) begin
      chk("pt:ready", 32'(in_ready), 32'd1);
      if (i > 0) begin
        chk("pt:wb_valid", 32'(wb_valid), 32'd1);
        chk("pt:wb_data", wb_data, pt_val[i-1]);
      end
      if (i < pt_val.size()) begin
        in_valid   = 1'b1;
        is_load    = 1'b0;
        is_store   = 1'b0;
        funct3     = 3'($urandom);
        alu_result = pt_val[i];
        rd         = 5'(i);
        reg_we     = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("pt:idle", 32'(wb_valid), 32'd0);

    // directed memory cases
    do_op("lb_103", 1, 0, 3'b000, 32'h103, 32'h0, 5'd3, 1, 0, 32'h80FF_FF11);
    do_op("sh_202", 0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd4, 1, 0, 32'h0);
    do_op("lw_delay4", 1, 0, 3'b010, 32'h400, 32'h0, 5'd7, 1, 4, 32'hCAFE_F00D);
    do_op("lw_ack_last", 1, 0, 3'b010, 32'h404, 32'h0, 5'd8, 1, TO - 1, 32'h1357_9BDF);
    do_op("lw_timeout", 1, 0, 3'b010, 32'h408, 32'h0, 5'd9, 1, TO, 32'h0);
    do_op("sw_timeout", 0, 1, 3'b010, 32'h40C, 32'h55, 5'd9, 1, TO + 3, 32'h0);
    do_op("lw_101", 1, 0, 3'b010, 32'h101, 32'h0, 5'd10, 1, 0, 32'hA5A5_1234);
    do_op("lhu_103", 1, 0, 3'b101, 32'h103, 32'h0, 5'd11, 1, 1, 32'h8001_7FFE);
    do_op("ld_st_both", 1, 1, 3'b100, 32'h3, 32'h0, 5'd12, 1, 0, 32'h9900_0000);

    // reset in the middle of an access
    in_valid   = 1'b1;
    is_load    = 1'b1;
    is_store   = 1'b0;
    funct3     = 3'b010;
    alu_result = 32'h500;
    rd         = 5'd1;
    reg_we     = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_mid:req_up", 32'(dmem_req), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid:req_async", 32'(dmem_req), 32'd0);
    chk("rst_mid:wb_valid", 32'(wb_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid:ready", 32'(in_ready), 32'd1);
    chk("rst_mid:no_wb", 32'(wb_valid), 32'd0);

    // randomized mix
    for (int i = 0; i < 200; i++) begin
      int kind;
      logic [2:0] f3;
      kind = $urandom_range(0, 2);
      if (kind == 2) f3 = st_f3[$urandom_range(0, 5)];
      else           f3 = 3'($urandom);
      do_op($sformatf("rnd%0d", i), kind == 1, (kind == 2) || (kind == 1 && ($urandom % 2) == 1),
            f3, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom_range(0, TO + 1), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
